// File: rtl/cd_abus_master.sv
// cd_abus_master: single-master A-bus access engine.
// Runs one write word or a read burst of LEN+1 words, each access built from
// SETUP, STROBE and RECOV phases paced by the A-bus rising clock-enable CE_R.
// AWAIT_N stretches STROBE; a wait longer than WAIT_MAX ticks aborts with ERR.
// Ports:
//   CLK, RST_N            system clock, asynchronous active-low reset
//   CE_R, CE_F            A-bus rising/falling clock-enable pulses
//   REQ, WE, ADDR, BE,    command: start, direction, word address, byte enables,
//   WDATA, LEN, AINC      write data, burst count minus one, address increment
//   BUSY, RDATA, RVALID,  status: busy, read data + per-word valid pulse,
//   DONE, ERR             completion pulse, sticky wait-timeout error
//   AA, ADO, ADI          A-bus address, data out, data in
//   ACS2_N, ARD_N,        A-bus chip select, read strobe,
//   AWRL_N, AWRU_N        lower/upper write strobes
//   AWAIT_N               slave wait request
module cd_abus_master #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic        REQ,
   input  logic        WE,
   input  logic [13:0] ADDR,
   input  logic [1:0]  BE,
   input  logic [15:0] WDATA,
   input  logic [7:0]  LEN,
   input  logic        AINC,
   output logic        BUSY,
   output logic [15:0] RDATA,
   output logic        RVALID,
   output logic        DONE,
   output logic        ERR,
   output logic [13:0] AA,
   output logic [15:0] ADO,
   input  logic [15:0] ADI,
   output logic        ACS2_N,
   output logic        ARD_N,
   output logic        AWRL_N,
   output logic        AWRU_N,
   input  logic        AWAIT_N
);

   localparam int unsigned AW  = 14;
   localparam int unsigned DW  = 16;
   localparam int unsigned CW  = 8;
   localparam int unsigned WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      RECOV  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   aa_q, aa_d;
   logic [DW-1:0]   ado_q, ado_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            rvalid_q, rvalid_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            we_q, we_d;
   logic [1:0]      be_q, be_d;
   logic            ainc_q, ainc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WCW-1:0]  wait_q, wait_d;
   logic            acs2_n_q, acs2_n_d;
   logic            ard_n_q, ard_n_d;
   logic            awrl_n_q, awrl_n_d;
   logic            awru_n_q, awru_n_d;

   // State and datapath registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         aa_q     <= '0;
         ado_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
         ainc_q   <= 1'b0;
         cnt_q    <= '0;
         wait_q   <= '0;
         acs2_n_q <= 1'b1;
         ard_n_q  <= 1'b1;
         awrl_n_q <= 1'b1;
         awru_n_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         aa_q     <= aa_d;
         ado_q    <= ado_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         we_q     <= we_d;
         be_q     <= be_d;
         ainc_q   <= ainc_d;
         cnt_q    <= cnt_d;
         wait_q   <= wait_d;
         acs2_n_q <= acs2_n_d;
         ard_n_q  <= ard_n_d;
         awrl_n_q <= awrl_n_d;
         awru_n_q <= awru_n_d;
      end
   end

   // Next-state, datapath and bus-pin decode
   always_comb begin
      state_d  = state_q;
      aa_d     = aa_q;
      ado_d    = ado_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      done_d   = 1'b0;
      err_d    = err_q;
      busy_d   = busy_q;
      we_d     = we_q;
      be_d     = be_q;
      ainc_d   = ainc_q;
      cnt_d    = cnt_q;
      wait_d   = wait_q;

      case (state_q)
         IDLE: begin
            // A REQ overlapping the DONE pulse belongs to the finished command
            if (REQ && !done_q) begin
               state_d = SETUP;
               aa_d    = ADDR;
               we_d    = WE;
               be_d    = BE;
               ainc_d  = AINC;
               cnt_d   = WE ? '0 : LEN;
               if (WE) begin
                  ado_d = WDATA;
               end
               busy_d  = 1'b1;
               err_d   = 1'b0;
            end
         end
         SETUP: begin
            if (CE_R) begin
               state_d = STROBE;
               wait_d  = '0;
            end
         end
         STROBE: begin
            if (CE_R) begin
               if (AWAIT_N) begin
                  state_d = RECOV;
                  if (!we_q) begin
                     rdata_d  = ADI;
                     rvalid_d = 1'b1;
                  end
               end else if (wait_q == WCW'(WAIT_MAX)) begin
                  // Wait timeout: drop the word and the rest of the burst
                  state_d = RECOV;
                  err_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  wait_d = wait_q + WCW'(1);
               end
            end
         end
         RECOV: begin
            if (CE_R) begin
               if (cnt_q != '0) begin
                  state_d = SETUP;
                  cnt_d   = cnt_q - CW'(1);
                  if (ainc_q) begin
                     aa_d = aa_q + AW'(1);
                  end
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Pins follow the state being entered so they change on the same edge
      acs2_n_d = !((state_d == SETUP) || (state_d == STROBE));
      ard_n_d  = !((state_d == STROBE) && !we_q);
      awrl_n_d = !((state_d == STROBE) && we_q && be_q[0]);
      awru_n_d = !((state_d == STROBE) && we_q && be_q[1]);
   end

   // Enables are expected to alternate, never overlap
   assert property (@(posedge CLK) disable iff (!RST_N) !(CE_R && CE_F))
      else $error("CE_R and CE_F asserted together");

   assign BUSY   = busy_q;
   assign RDATA  = rdata_q;
   assign RVALID = rvalid_q;
   assign DONE   = done_q;
   assign ERR    = err_q;
   assign AA     = aa_q;
   assign ADO    = ado_q;
   assign ACS2_N = acs2_n_q;
   assign ARD_N  = ard_n_q;
   assign AWRL_N = awrl_n_q;
   assign AWRU_N = awru_n_q;

endmodule
